// File: rtl/ccd_line_capture_if.sv
// Output stream interface for ccd_line_capture: corrected pixel data with
// valid/ready/last handshake. The capture block drives it through the master
// modport; the downstream consumer (line storage or host link) uses slave.
interface ccd_line_capture_if #(
  parameter int DATA_W = 12
);
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (
    output out_data,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/ccd_line_capture.sv
// ccd_line_capture: per-line CCD pixel framer.
// Drops the leading dummy pixels of each line, averages the optically-black
// pixels into a dark level and emits dark-corrected active pixels through a
// small first-word-fall-through FIFO with valid/ready/last.
//
// Optional feature macro: DARK_CLAMP_EN
//   defined   - dark pixels are averaged and subtracted (saturating at 0)
//   undefined - dark pixels are consumed and discarded, dark_level_o is 0 and
//               active pixels are forwarded raw
module ccd_line_capture #(
  parameter int DATA_W     = 12,
  parameter int SKIP_PIX   = 32,
  parameter int DARK_PIX   = 16,
  parameter int ACTIVE_PIX = 3648,
  parameter int FIFO_DEPTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               line_start_i,
  input  logic [DATA_W-1:0]  pix_in_i,
  input  logic               pix_in_valid_i,
  ccd_line_capture_if.master out_if,
  output logic [DATA_W-1:0]  dark_level_o,
  output logic               busy_o,
  output logic               err_o,
  input  logic               err_clr_i
);

  localparam int MAX_SD  = (SKIP_PIX > DARK_PIX) ? SKIP_PIX : DARK_PIX;
  localparam int MAX_CNT = (MAX_SD > ACTIVE_PIX) ? MAX_SD : ACTIVE_PIX;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] SKIP_LAST   = CNT_W'((SKIP_PIX > 0) ? SKIP_PIX - 1 : 0);
  localparam logic [CNT_W-1:0] DARK_LAST   = CNT_W'(DARK_PIX - 1);
  localparam logic [CNT_W-1:0] ACTIVE_LAST = CNT_W'(ACTIVE_PIX - 1);

  typedef enum logic [1:0] {
    IDLE,
    SKIP,
    DARK,
    ACTIVE
  } state_t;

  // With no dummy pixels a new line goes straight to dark averaging.
  localparam state_t FIRST_STATE = (SKIP_PIX == 0) ? DARK : SKIP;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  pixCount_q, pixCount_d;
  logic              err_q, err_d;
  logic              abortLine;
  logic              fifoWrite;
  logic              wrLast;
  logic [DATA_W-1:0] wrData;
  logic [DATA_W-1:0] darkLevel;

  logic [DATA_W:0]   fifoMem_q [FIFO_DEPTH];
  logic [PTR_W:0]    wrPtr_q, rdPtr_q;
  logic              fifoEmpty;
  logic              fifoFull;
  logic              fifoPop;
  logic              fifoPush;
  logic              fifoDrop;
  logic [DATA_W:0]   fifoHead;

  // Sequencer: line_start always restarts the line (and flags an abort if a
  // line was in progress); otherwise each sample strobe advances the phase
  // counter, and the last strobe of a phase hands over to the next phase.
  always_comb begin
    state_d    = state_q;
    pixCount_d = pixCount_q;
    abortLine  = 1'b0;
    fifoWrite  = 1'b0;
    wrLast     = 1'b0;
    if (line_start_i) begin
      abortLine  = (state_q != IDLE);
      state_d    = FIRST_STATE;
      pixCount_d = '0;
    end else if (pix_in_valid_i) begin
      case (state_q)
        IDLE: begin
        end
        SKIP: begin
          if (pixCount_q == SKIP_LAST) begin
            state_d    = DARK;
            pixCount_d = '0;
          end else begin
            pixCount_d = pixCount_q + CNT_W'(1);
          end
        end
        DARK: begin
          if (pixCount_q == DARK_LAST) begin
            state_d    = ACTIVE;
            pixCount_d = '0;
          end else begin
            pixCount_d = pixCount_q + CNT_W'(1);
          end
        end
        ACTIVE: begin
          fifoWrite = 1'b1;
          if (pixCount_q == ACTIVE_LAST) begin
            wrLast     = 1'b1;
            state_d    = IDLE;
            pixCount_d = '0;
          end else begin
            pixCount_d = pixCount_q + CNT_W'(1);
          end
        end
        default: begin
          state_d    = IDLE;
          pixCount_d = '0;
        end
      endcase
    end
  end

  // Sequencer state and phase counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pixCount_q <= '0;
    end else begin
      state_q    <= state_d;
      pixCount_q <= pixCount_d;
    end
  end

`ifdef DARK_CLAMP_EN
  localparam int DARK_LOG = $clog2(DARK_PIX);
  localparam int SUM_W    = DATA_W + DARK_LOG;

  logic [SUM_W-1:0]  darkSum_q, darkSum_d;
  logic [SUM_W-1:0]  darkSumNext;
  logic [DATA_W-1:0] darkLevel_q, darkLevel_d;
  logic              darkStrobe;
  logic              darkFinal;

  assign darkStrobe  = (state_q == DARK) && pix_in_valid_i && !line_start_i;
  assign darkFinal   = darkStrobe && (pixCount_q == DARK_LAST);
  assign darkSumNext = darkSum_q + SUM_W'(pix_in_i);

  // Dark accumulator: cleared at every line start, summed over the dark phase;
  // the final strobe (including its own sample) yields the new average.
  always_comb begin
    darkSum_d   = darkSum_q;
    darkLevel_d = darkLevel_q;
    if (line_start_i) begin
      darkSum_d = '0;
    end else if (darkFinal) begin
      darkSum_d   = '0;
      darkLevel_d = DATA_W'(darkSumNext >> DARK_LOG);
    end else if (darkStrobe) begin
      darkSum_d = darkSumNext;
    end
  end

  // Dark accumulator and latched dark level registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      darkSum_q   <= '0;
      darkLevel_q <= '0;
    end else begin
      darkSum_q   <= darkSum_d;
      darkLevel_q <= darkLevel_d;
    end
  end

  assign darkLevel = darkLevel_q;

  // Dark correction saturates at zero instead of wrapping below black.
  always_comb begin
    wrData = '0;
    if (pix_in_i >= darkLevel_q) begin
      wrData = pix_in_i - darkLevel_q;
    end
  end
`else
  assign darkLevel = '0;
  assign wrData    = pix_in_i;
`endif

  assign dark_level_o = darkLevel;
  assign busy_o       = (state_q != IDLE);

  // FIFO bookkeeping: pointers carry one extra wrap bit to tell full from
  // empty. A write into a full FIFO only lands if the head leaves this cycle.
  assign fifoEmpty = (wrPtr_q == rdPtr_q);
  assign fifoFull  = (wrPtr_q[PTR_W] != rdPtr_q[PTR_W]) &&
                     (wrPtr_q[PTR_W-1:0] == rdPtr_q[PTR_W-1:0]);
  assign fifoPop   = !fifoEmpty && out_if.out_ready;
  assign fifoPush  = fifoWrite && (!fifoFull || fifoPop);
  assign fifoDrop  = fifoWrite && fifoFull && !fifoPop;

  // FIFO read/write pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      if (fifoPush) begin
        wrPtr_q <= wrPtr_q + (PTR_W + 1)'(1);
      end
      if (fifoPop) begin
        rdPtr_q <= rdPtr_q + (PTR_W + 1)'(1);
      end
    end
  end

  // FIFO storage; entries are {last, data}. Contents need no reset because
  // the outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (fifoPush) begin
      fifoMem_q[wrPtr_q[PTR_W-1:0]] <= {wrLast, wrData};
    end
  end

  assign fifoHead         = fifoMem_q[rdPtr_q[PTR_W-1:0]];
  assign out_if.out_valid = !fifoEmpty;
  assign out_if.out_data  = fifoEmpty ? '0 : fifoHead[DATA_W-1:0];
  assign out_if.out_last  = !fifoEmpty && fifoHead[DATA_W];

  // Sticky error: an aborted line or a dropped pixel sets it, and a set in the
  // same cycle as a clear request takes priority.
  always_comb begin
    err_d = err_q;
    if (err_clr_i) begin
      err_d = 1'b0;
    end
    if (abortLine || fifoDrop) begin
      err_d = 1'b1;
    end
  end

  // Sticky error register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;

endmodule

// File: doc/ccd_line_capture.md
# ccd_line_capture

Per-line pixel framer that sits directly downstream of the AD9235 capture stage. Consumes the digitised CCD sample stream, discards leading dummy pixels and averages the optically-black (dark) pixels into a per-line dark level. Emits dark-corrected active pixels through a small FIFO with a valid/ready/last handshake, toward line storage or the host link.

## Interface
- `DATA_W`, 12: sample width.
- `SKIP_PIX`, 32: leading dummy pixels dropped after each line start; 0 allowed.
- `DARK_PIX`, 16: dark pixels averaged; power of two, ≥1.
- `ACTIVE_PIX`, 3648: active pixels emitted per line; ≥1.
- `FIFO_DEPTH`, 16: output FIFO entries; power of two, ≥2.

- `clk`  in  1: 100 MHz system clock; all logic on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `line_start`  in  1: one-cycle pulse marking the start of a CCD readout line.
- `pix_in`  in  DATA_W: sample from the ADC capture stage.
- `pix_in_valid`  in  1: one-cycle strobe; `pix_in` is valid this cycle, already synchronised to `clk`.
- `out_data`  out  DATA_W: corrected pixel at the FIFO head.
- `out_valid`  out  1: FIFO not empty.
- `out_ready`  in  1: consumer accepts `out_data` when `out_valid & out_ready`.
- `out_last`  out  1: head entry is the final active pixel of its line.
- `dark_level`  out  DATA_W: dark level latched for the current or most recent line.
- `busy`  out  1: state ≠ IDLE.
- `err`  out  1: sticky error flag.
- `err_clr`  in  1: clears `err`.

## Operation
- FSM states: IDLE → SKIP → DARK → ACTIVE → IDLE. A pixel counter counts accepted `pix_in_valid` strobes within the current phase.
- IDLE: `pix_in_valid` is ignored. `line_start` moves to SKIP, or to DARK when `SKIP_PIX`=0. Counter and dark accumulator clear.
- SKIP: counts `SKIP_PIX` strobes, then moves to DARK. Samples are discarded.
- DARK: accumulates samples into a `DATA_W+log2(DARK_PIX)`-bit sum. On the `DARK_PIX`-th strobe, `dark_level` ← sum >> log2(DARK_PIX), including the current sample, and the FSM moves to ACTIVE.
- ACTIVE: each strobe writes `{pix_in − dark_level saturated at 0, last}` into the FIFO. `last`=1 on the `ACTIVE_PIX`-th strobe, which also returns the FSM to IDLE.
- `line_start` while not IDLE aborts the line: `err` ← 1, restart at SKIP (or DARK) with counters cleared. FIFO contents are kept; no `out_last` is generated for the aborted line.
- `line_start` and `pix_in_valid` in the same cycle: `line_start` wins and the sample is discarded.
- FIFO full on an ACTIVE write without a same-cycle pop: the sample is dropped, `err` ← 1, and the pixel counter still advances. Full with a same-cycle pop: the write succeeds.
- `err` set and `err_clr` in the same cycle: set wins.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_last`=0, `dark_level`=0, `busy`=0, `err`=0. FIFO is empty and the FSM is in IDLE.
- Latency: an ACTIVE sample strobed in cycle n appears on `out_data` with `out_valid`=1 in cycle n+1 when the FIFO was empty (first-word-fall-through).
- `dark_level` updates in the cycle after the final dark strobe and holds until the next line's DARK completes.
- `out_data`/`out_last` stay stable while `out_valid & !out_ready`.
- Throughput: one write and one pop per cycle, sustained.

## Configuration
- `DARK_CLAMP_EN` defined: dark averaging and subtraction behave as described above.
- `DARK_CLAMP_EN` undefined:
  - DARK still consumes `DARK_PIX` strobes and discards them.
  - `dark_level` is tied to 0.
  - ACTIVE writes raw `pix_in`.

## Test plan
- SKIP=4, DARK=4, ACTIVE=8, `out_ready`=1: `line_start`, then 16 strobes: 4 skip of 0xFFF, 4 dark of 100/102/98/104, 8 active of 500. Expect 8 outputs of 399, `dark_level`=101, `out_last` only on the 8th, `busy` low afterward.
- Same line with an active sample of 50: output is 0 (saturation), not a wrapped value.
- `out_ready`=0 with FIFO_DEPTH=4 and ACTIVE=8: first 4 pixels are held, the remaining 4 are dropped, `err`=1. Raise `out_ready`: exactly 4 words drain, none with `out_last`.
- `line_start` after 3 active pixels: `err`=1. The restarted line yields a full 8 outputs with `out_last` on the final one. `err_clr` and a new error in the same cycle leaves `err`=1.
- `line_start` coincident with a strobe: that sample is discarded, so the line needs 16 further strobes to complete. Assert `rst` mid-line: all outputs return to reset values at once.
- Build without `DARK_CLAMP_EN`: the first stimulus outputs 500 ×8 and `dark_level` stays 0.
